// File: rtl/mem_responder.sv
// mem_responder: single-word bus responder between the CPU and board memory.
// Each transaction is decoded into internal block RAM, an external region
// served over a req/ack handshake with timeout, or unmapped space.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   address[26:0]        word address, sampled with start
//   data[31:0], we       write data and direction (1 = write), sampled with start
//   start                one-cycle transaction request
//   q[31:0]              registered read data, updated only when a read completes
//   busy                 transaction in progress (includes the start cycle)
//   ext_addr/wdata/we    latched transaction fields for the external side
//   ext_req              external request level, high for the whole EXT state
//   ext_ack, ext_rdata   external completion pulse and its read data
//   bus_err              one-cycle pulse in the last EXT cycle on timeout
module mem_responder #(
  parameter int RAM_AW  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] address,
  input  logic [31:0] data,
  input  logic        we,
  input  logic        start,
  output logic [31:0] q,
  output logic        busy,
  output logic [25:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic        ext_we,
  output logic        ext_req,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    RAM_ADDR,
    RAM_DATA,
    EXT,
    UNMAP
  } state_t;

  // The counter holds the number of EXT cycles already completed, so the
  // final permitted cycle is the one where it equals TIMEOUT-1.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [25:0]       addr_r;
  logic [31:0]       wdata_r;
  logic              we_r;
  logic [15:0]       cnt;
  logic [31:0]       ram_q;
  logic [31:0]       mem [0:(1 << RAM_AW) - 1];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_ext;
  logic              is_ram;
  logic              expire;

  // Decoding happens in the start cycle on the bus value, which is exactly
  // the value being latched, so only the low 26 bits need to be kept.
  assign is_ext  = ~address[26];
  assign is_ram  = address[26] & ((address[25:0] >> RAM_AW) == 26'd0);
  assign expire  = (cnt == LAST_CNT);
  assign ram_idx = addr_r[RAM_AW-1:0];

  assign ext_addr  = addr_r;
  assign ext_wdata = wdata_r;
  assign ext_we    = we_r;

  // Next-state and output logic. An ack arriving in the expiry cycle wins,
  // which is why bus_err is masked by ext_ack.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE) | ((state == IDLE) & start);
    ext_req    = 1'b0;
    bus_err    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_ext)      state_next = EXT;
          else if (is_ram) state_next = RAM_ADDR;
          else             state_next = UNMAP;
        end
      end
      RAM_ADDR: state_next = RAM_DATA;
      RAM_DATA: state_next = IDLE;
      EXT: begin
        ext_req = 1'b1;
        if (ext_ack) begin
          state_next = IDLE;
        end else if (expire) begin
          bus_err    = 1'b1;
          state_next = IDLE;
        end
      end
      UNMAP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, transaction latch, timeout counter and read-data register.
  // q only moves when a read completes; writes and abandoned transactions
  // leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_r  <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
      cnt     <= '0;
      q       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            addr_r  <= address[25:0];
            wdata_r <= data;
            we_r    <= we;
            cnt     <= '0;
          end
        end
        RAM_DATA: begin
          if (!we_r) q <= ram_q;
        end
        EXT: begin
          cnt <= cnt + 16'd1;
          if (ext_ack) begin
            if (!we_r) q <= ext_rdata;
          end else if (expire) begin
            if (!we_r) q <= '0;
          end
        end
        UNMAP: begin
          if (!we_r) q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Block RAM kept free of reset so it maps onto a synchronous RAM primitive.
  // The access is suppressed while reset is asserted so an abandoned write
  // never lands.
  always_ff @(posedge clk) begin
    if (!reset && state == RAM_ADDR) begin
      if (we_r) mem[ram_idx] <= wdata_r;
      ram_q <= mem[ram_idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed testbench for mem_responder (RAM_AW=10, TIMEOUT=4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [26:0] address;
  logic [31:0] data;
  logic        we;
  logic        start;
  logic [31:0] q;
  logic        busy;
  logic [25:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_we;
  logic        ext_req;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        bus_err;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_responder #(.RAM_AW(10), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .we        (we),
    .start     (start),
    .q         (q),
    .busy      (busy),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_we    (ext_we),
    .ext_req   (ext_req),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle, dropping the one-cycle pulses.
  task automatic next_cycle();
    @(negedge clk);
    start   = 1'b0;
    ext_ack = 1'b0;
    #1;
  endtask

  // Present a transaction in the current cycle (this becomes T0).
  task automatic begin_txn(input logic [26:0] a, input logic [31:0] d, input logic w);
    address = a;
    data    = d;
    we      = w;
    start   = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; we = 1'b0; address = '0; data = '0;
    ext_ack = 1'b0; ext_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (q !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_q: got %h want 00000000", q); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (ext_req !== 1'b0 || bus_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_req_err: got req=%b err=%b want 0 0", ext_req, bus_err);
    end
    tests_run++;
    if (ext_addr !== 26'h0 || ext_wdata !== 32'h0 || ext_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ext_fields: got %h %h %b want 0 0 0", ext_addr, ext_wdata, ext_we);
    end
  endtask

  // One internal-RAM transaction: busy for T0..T2, then idle with q in T3.
  task automatic ram_txn(input logic [26:0] a, input logic [31:0] d, input logic w,
                         input logic [31:0] q_exp, input string name);
    begin_txn(a, d, w);
    for (int t = 0; t < 3; t++) begin
      if (t > 0) next_cycle();
      tests_run++;
      if (busy !== 1'b1 || ext_req !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s_busy_T%0d: got busy=%b req=%b want 1 0", name, t, busy, ext_req);
      end
    end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0 || q !== q_exp) begin
      tests_failed++;
      $display("[TB] FAIL %s_T3: got busy=%b q=%h want 0 %h", name, busy, q, q_exp);
    end
  endtask

  // One unmapped transaction: busy for T0..T1, no ext_req, idle with q in T2.
  task automatic unmap_txn(input logic [26:0] a, input logic [31:0] d, input logic w,
                           input logic [31:0] q_exp, input string name);
    begin_txn(a, d, w);
    for (int t = 0; t < 2; t++) begin
      if (t > 0) next_cycle();
      tests_run++;
      if (busy !== 1'b1 || ext_req !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s_busy_T%0d: got busy=%b req=%b want 1 0", name, t, busy, ext_req);
      end
    end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0 || q !== q_exp || ext_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_T2: got busy=%b q=%h req=%b want 0 %h 0", name, busy, q, ext_req, q_exp);
    end
  endtask

  task automatic test_ram();
    next_cycle();
    ram_txn(27'h4000005, 32'h1234ABCD, 1'b1, 32'h00000000, "ram_wr");
    ram_txn(27'h4000005, 32'h00000000, 1'b0, 32'h1234ABCD, "ram_rd");
    ram_txn(27'h40003FF, 32'h55AA55AA, 1'b1, 32'h1234ABCD, "ram_top_wr");
    ram_txn(27'h40003FF, 32'h00000000, 1'b0, 32'h55AA55AA, "ram_top_rd");
  endtask

  task automatic test_unmap();
    unmap_txn(27'h7FFFFFF, 32'hFFFFFFFF, 1'b1, 32'h55AA55AA, "unmap_wr");
    unmap_txn(27'h4000400, 32'h00000000, 1'b0, 32'h00000000, "unmap_edge_rd");
    unmap_txn(27'h7FFFFFF, 32'h00000000, 1'b0, 32'h00000000, "unmap_rd");
  endtask

  // Ack three cycles after ext_req rises (T4), which is also the expiry
  // cycle for TIMEOUT=4: the ack must win.
  task automatic test_ext_read();
    next_cycle();
    begin_txn(27'h0000100, 32'h0, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || ext_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ext_rd_T0: got busy=%b req=%b want 1 0", busy, ext_req);
    end
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      if (t == 4) begin
        ext_ack = 1'b1; ext_rdata = 32'hCAFEF00D;
        #1;
      end
      tests_run++;
      if (ext_req !== 1'b1 || busy !== 1'b1 || ext_addr !== 26'h100 || ext_we !== 1'b0 || bus_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ext_rd_T%0d: got req=%b busy=%b addr=%h we=%b err=%b want 1 1 100 0 0",
                 t, ext_req, busy, ext_addr, ext_we, bus_err);
      end
    end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0 || ext_req !== 1'b0 || q !== 32'hCAFEF00D || bus_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ext_rd_done: got busy=%b req=%b q=%h err=%b want 0 0 cafef00d 0",
               busy, ext_req, q, bus_err);
    end
  endtask

  // External write acked in T1: idle in T2, q untouched.
  task automatic test_ext_write_fast();
    begin_txn(27'h0123456, 32'h0BADCAFE, 1'b1);
    next_cycle();
    ext_ack = 1'b1; ext_rdata = 32'h77777777;
    #1;
    tests_run++;
    if (ext_req !== 1'b1 || ext_addr !== 26'h0123456 || ext_wdata !== 32'h0BADCAFE || ext_we !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ext_wr_fields: got req=%b addr=%h wdata=%h we=%b want 1 0123456 0badcafe 1",
               ext_req, ext_addr, ext_wdata, ext_we);
    end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0 || q !== 32'hCAFEF00D) begin
      tests_failed++; $display("[TB] FAIL ext_wr_done: got busy=%b q=%h want 0 cafef00d", busy, q);
    end
  endtask

  task automatic test_timeout();
    int err_pulses;
    err_pulses = 0;
    begin_txn(27'h0000200, 32'h0, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      next_cycle();
      if (bus_err === 1'b1) err_pulses++;
      tests_run++;
      if (ext_req !== 1'b1 || bus_err !== (t == 4)) begin
        tests_failed++;
        $display("[TB] FAIL tmo_T%0d: got req=%b err=%b want 1 %b", t, ext_req, bus_err, (t == 4));
      end
    end
    next_cycle();
    if (bus_err === 1'b1) err_pulses++;
    tests_run++;
    if (ext_req !== 1'b0 || busy !== 1'b0 || q !== 32'h0 || err_pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL tmo_done: got req=%b busy=%b q=%h pulses=%0d want 0 0 00000000 1",
               ext_req, busy, q, err_pulses);
    end
    next_cycle();
    next_cycle();
    ext_ack = 1'b1; ext_rdata = 32'hFFFFFFFF;
    #1;
    next_cycle();
    tests_run++;
    if (q !== 32'h0 || busy !== 1'b0 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tmo_late_ack: got q=%h busy=%b err=%b want 00000000 0 0", q, busy, bus_err);
    end
  endtask

  // A start during RAM_ADDR must not be latched or queued.
  task automatic test_back_to_back();
    ram_txn(27'h4000021, 32'h00000021, 1'b1, 32'h0, "b2b_pre");
    begin_txn(27'h4000020, 32'hA5A5A5A5, 1'b1);
    next_cycle();
    begin_txn(27'h4000021, 32'h5A5A5A5A, 1'b1);
    next_cycle();
    tests_run++;
    if (busy !== 1'b1 || ext_addr !== 26'h0000020 || ext_wdata !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("[TB] FAIL b2b_latch: got busy=%b addr=%h wdata=%h want 1 0000020 a5a5a5a5",
               busy, ext_addr, ext_wdata);
    end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_T3_busy: got %b want 0", busy); end
    next_cycle();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_no_queue: got %b want 0", busy); end
    ram_txn(27'h4000020, 32'h0, 1'b0, 32'hA5A5A5A5, "b2b_rd_first");
    ram_txn(27'h4000021, 32'h0, 1'b0, 32'h00000021, "b2b_rd_second");
  endtask

  task automatic test_reset_mid();
    begin_txn(27'h0000300, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    tests_run++;
    if (ext_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_req: got %b want 1", ext_req); end
    reset = 1'b1;
    ext_ack = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    tests_run++;
    if (ext_req !== 1'b0 || busy !== 1'b0 || q !== 32'h0 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_state: got req=%b busy=%b q=%h err=%b want 0 0 00000000 0",
               ext_req, busy, q, bus_err);
    end
    next_cycle();
    ram_txn(27'h4000005, 32'h0, 1'b0, 32'h1234ABCD, "rstmid_ram_rd");
  endtask

  initial begin
    test_reset();
    test_ram();
    test_unmap();
    test_ext_read();
    test_ext_write_fast();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
